seg7_mux_decoder: RTL and testbench

//  Receive-side inverse of the two-digit BCD-to-7-segment driver.

---
 rtl/seg7_mux_decoder.sv | 178 +++++++++++++++++
 tb/tb_seg7_mux_decoder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_mux_decoder.sv
// seg7_mux_decoder
// Receive-side decoder for a time-multiplexed, active-low two-digit 7-segment bus.
// Each digit's {dig_n, seg_n} pattern must hold steady for STABLE_CYC cycles before
// it is captured. After the ones digit and then the tens digit are captured, the
// block reports tens*10+ones (0..99) on value with a one-cycle value_valid pulse.
// If either captured pattern is illegal, it pulses err instead.
// A frame whose tens digit never arrives is abandoned after TIMEOUT_CYC cycles and
// flagged through the stale level.

module seg7_mux_decoder #(
    parameter int STABLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [0:6] seg_n,
    input  logic [1:0] dig_n,
    output logic [6:0] value,
    output logic       value_valid,
    output logic       err,
    output logic       stale
);

    localparam int SW = (STABLE_CYC > 2) ? $clog2(STABLE_CYC) : 1;
    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYC - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_ONES = 2'd0,
        S_TENS = 2'd1,
        S_EMIT = 2'd2
    } state_t;

    // Decodes one segment pattern into {legal, digit}.
    // An all-blank pattern is accepted only on the tens digit, where it reads as 0.
    function automatic logic [4:0] seg_decode(input logic [0:6] pat, input logic is_tens);
        logic [4:0] res;
        case (pat)
            7'b0000001: res = {1'b1, 4'd0};
            7'b1001111: res = {1'b1, 4'd1};
            7'b0010010: res = {1'b1, 4'd2};
            7'b0000110: res = {1'b1, 4'd3};
            7'b1001100: res = {1'b1, 4'd4};
            7'b0100100: res = {1'b1, 4'd5};
            7'b0100000: res = {1'b1, 4'd6};
            7'b0001111: res = {1'b1, 4'd7};
            7'b0000000: res = {1'b1, 4'd8};
            7'b0001100: res = {1'b1, 4'd9};
            7'b1111111: res = {is_tens, 4'd0};
            default:    res = {1'b0, 4'd0};
        endcase
        return res;
    endfunction

    // Combines the two digits as tens*10+ones in 7 bits.
    // The product is built from shifts, and the sum cannot exceed 99.
    function automatic logic [6:0] combine(input logic [3:0] tens, input logic [3:0] ones);
        logic [6:0] t7;
        t7 = {3'b000, tens};
        return (t7 << 3) + (t7 << 1) + {3'b000, ones};
    endfunction

    state_t          state_r, state_s;
    logic [8:0]      prev_r;
    logic [8:0]      cur_s;
    logic [SW-1:0]   stab_cnt_r, stab_next_s;
    logic            capture_s, ones_cap_s, tens_cap_s;
    logic [TW-1:0]   to_cnt_r, to_cnt_s;
    logic [0:6]      ones_pat_r, ones_pat_s;
    logic [6:0]      value_r, value_s;
    logic            valid_r, valid_s;
    logic            err_r, err_s;
    logic            stale_r, stale_s;
    logic [4:0]      ones_dec_s, tens_dec_s;

    assign cur_s = {dig_n, seg_n};

    // Stability counter: restarts on any bus change and saturates at the capture count.
    always_comb begin
        stab_next_s = '0;
        if (cur_s != prev_r) begin
            stab_next_s = '0;
        end else if (stab_cnt_r == STAB_LAST) begin
            stab_next_s = stab_cnt_r;
        end else begin
            stab_next_s = stab_cnt_r + 1'b1;
        end
    end

    // A capture fires once per stable period, and only when exactly one digit is selected.
    assign capture_s  = (stab_next_s == STAB_LAST) && (stab_cnt_r != STAB_LAST);
    assign ones_cap_s = capture_s && (dig_n == 2'b10);
    assign tens_cap_s = capture_s && (dig_n == 2'b01);

    assign ones_dec_s = seg_decode(ones_pat_r, 1'b0);
    assign tens_dec_s = seg_decode(seg_n, 1'b1);

    // Frame sequencing: compute next state, timeout counter, ones capture and output values.
    always_comb begin
        state_s    = state_r;
        to_cnt_s   = to_cnt_r;
        ones_pat_s = ones_pat_r;
        value_s    = value_r;
        valid_s    = 1'b0;
        err_s      = 1'b0;
        stale_s    = stale_r;
        case (state_r)
            S_ONES: begin
                if (ones_cap_s) begin
                    ones_pat_s = seg_n;
                    to_cnt_s   = '0;
                    state_s    = S_TENS;
                end else begin
                    state_s = S_ONES;
                end
            end
            S_TENS: begin
                if (tens_cap_s) begin
                    // Results are registered here, so they appear in the first S_EMIT cycle.
                    state_s = S_EMIT;
                    if (ones_dec_s[4] && tens_dec_s[4]) begin
                        value_s = combine(tens_dec_s[3:0], ones_dec_s[3:0]);
                        valid_s = 1'b1;
                        stale_s = 1'b0;
                    end else begin
                        err_s = 1'b1;
                    end
                end else if (ones_cap_s) begin
                    ones_pat_s = seg_n;
                    to_cnt_s   = '0;
                end else if (to_cnt_r == TO_LAST) begin
                    stale_s = 1'b1;
                    state_s = S_ONES;
                end else begin
                    to_cnt_s = to_cnt_r + 1'b1;
                end
            end
            S_EMIT: begin
                state_s = S_ONES;
            end
            default: begin
                state_s = S_ONES;
            end
        endcase
    end

    // State, capture and output registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_ONES;
            prev_r     <= 9'd0;
            stab_cnt_r <= '0;
            to_cnt_r   <= '0;
            ones_pat_r <= 7'd0;
            value_r    <= 7'd0;
            valid_r    <= 1'b0;
            err_r      <= 1'b0;
            stale_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            prev_r     <= cur_s;
            stab_cnt_r <= stab_next_s;
            to_cnt_r   <= to_cnt_s;
            ones_pat_r <= ones_pat_s;
            value_r    <= value_s;
            valid_r    <= valid_s;
            err_r      <= err_s;
            stale_r    <= stale_s;
        end
    end

    assign value       = value_r;
    assign value_valid = valid_r;
    assign err         = err_r;
    assign stale       = stale_r;

endmodule

// File: tb/tb_seg7_mux_decoder.sv
// Testbench for seg7_mux_decoder.
// Each frame's expected result is queued when the frame is driven.
// A monitor then pops and compares an entry whenever value_valid or err pulses.

module tb_seg7_mux_decoder;

    localparam logic [0:6] P0 = 7'b0000001;
    localparam logic [0:6] P1 = 7'b1001111;
    localparam logic [0:6] P2 = 7'b0010010;
    localparam logic [0:6] P3 = 7'b0000110;
    localparam logic [0:6] P4 = 7'b1001100;
    localparam logic [0:6] P5 = 7'b0100100;
    localparam logic [0:6] P6 = 7'b0100000;
    localparam logic [0:6] P7 = 7'b0001111;
    localparam logic [0:6] P8 = 7'b0000000;
    localparam logic [0:6] P9 = 7'b0001100;
    localparam logic [0:6] PB = 7'b1111111;
    localparam logic [0:6] PX = 7'b1111110;

    logic       clk;
    logic       rst;
    logic [0:6] seg_n;
    logic [1:0] dig_n;
    logic [6:0] value;
    logic       value_valid;
    logic       err;
    logic       stale;

    typedef struct {
        bit is_err;
        int val;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   pulse_cnt    = 0;

    seg7_mux_decoder #(.STABLE_CYC(4), .TIMEOUT_CYC(1000)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_n       (seg_n),
        .dig_n       (dig_n),
        .value       (value),
        .value_valid (value_valid),
        .err         (err),
        .stale       (stale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        tests_run++;
        if (obs != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor: every output pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && (value_valid || err)) begin
            pulse_cnt++;
            check("vv_err_exclusive", int'(value_valid & err), 0);
            if (sb_q.size() == 0) begin
                check("spurious_pulse", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check("pulse_kind_err", int'(err), mon_e.is_err ? 1 : 0);
                check("value", int'(value), mon_e.val);
            end
        end
    end

    // Drives one bus state, then waits n clocks; returns #1 after a rising edge.
    task automatic show(input logic [1:0] d, input logic [0:6] s, input int n);
        dig_n = d;
        seg_n = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [0:6] op, input logic [0:6] tp,
                         input bit exp_err, input int exp_val);
        exp_t e;
        e.is_err = exp_err;
        e.val    = exp_val;
        sb_q.push_back(e);
        show(2'b10, op, 4);
        show(2'b11, PB, 2);
        show(2'b01, tp, 4);
        check("emit_latency", int'(value_valid | err), 1);
        show(2'b11, PB, 3);
    endtask

    initial begin
        int base;
        int n;
        rst   = 1'b1;
        dig_n = 2'b11;
        seg_n = PB;
        repeat (3) @(posedge clk);
        #1;
        check("reset_value", int'(value), 0);
        check("reset_valid", int'(value_valid), 0);
        check("reset_err", int'(err), 0);
        check("reset_stale", int'(stale), 0);
        rst = 1'b0;
        show(2'b11, PB, 3);

        // Basic frame: ones=5, tens=2.
        frame(P5, P2, 1'b0, 25);
        check("t1_stale", int'(stale), 0);

        // Illegal ones pattern: err pulses and value holds.
        frame(PX, P1, 1'b1, 25);
        check("t3_value_held", int'(value), 25);

        // Blank tens reads as 0; upper bound; a repeated value pulses again; blank ones is illegal.
        frame(P7, PB, 1'b0, 7);
        frame(P9, P9, 1'b0, 99);
        frame(P9, P9, 1'b0, 99);
        frame(PB, P3, 1'b1, 99);
        frame(P8, P6, 1'b0, 68);

        // Unstable ones, tens while in S_ONES, and both selects low must never capture.
        base = pulse_cnt;
        show(2'b10, P5, 2);
        show(2'b10, P6, 2);
        show(2'b11, PB, 2);
        show(2'b01, P2, 6);
        show(2'b11, PB, 2);
        show(2'b00, P8, 10);
        show(2'b01, P4, 6);
        show(2'b11, PB, 3);
        check("t4_no_capture", pulse_cnt - base, 0);

        // Timeout: ones captured, tens never arrives.
        base = pulse_cnt;
        show(2'b10, P3, 4);
        dig_n = 2'b11;
        seg_n = PB;
        n = 0;
        while (!stale && n < 1200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t5_stale_set", int'(stale), 1);
        check("t5_timeout_cycles", n, 1000);
        check("t5_no_pulse", pulse_cnt - base, 0);
        show(2'b01, P2, 6);
        check("t5_tens_ignored", pulse_cnt - base, 0);
        show(2'b11, PB, 2);
        frame(P9, P1, 1'b0, 19);
        check("t5_stale_cleared", int'(stale), 0);

        // Reset asserted while in S_TENS.
        show(2'b10, P4, 4);
        show(2'b11, PB, 3);
        rst = 1'b1;
        #1;
        check("t6_async_value", int'(value), 0);
        check("t6_async_valid", int'(value_valid), 0);
        check("t6_async_stale", int'(stale), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        base = pulse_cnt;
        show(2'b11, PB, 2);
        show(2'b01, P7, 6);
        check("t6_frame_dropped", pulse_cnt - base, 0);
        show(2'b11, PB, 2);
        frame(P3, P0, 1'b0, 3);
        check("t6_value", int'(value), 3);
        check("t6_stale", int'(stale), 0);

        show(2'b11, PB, 5);
        check("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
